// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// A single shift-add / restoring-divide datapath runs 32 iterations per MULT*/DIV*.
// Signed operations work on magnitudes, and a final FIX cycle applies the result signs.
// MTHI/MTLO bypass the datapath and write the selected register at the accept edge.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   acc_hi_reg;     // partial product high half / running remainder
    logic [WIDTH-1:0]   acc_lo_reg;     // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]   oper_reg;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   raw_a_reg;      // unmodified dividend, returned in HI on divide-by-zero
    logic               is_div_reg;
    logic               neg_lo_reg;     // negate product, or negate quotient
    logic               neg_hi_reg;     // negate remainder (sign of dividend)
    logic               zero_div_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, div_zero_reg;

    // operand decode and magnitude extraction at accept time
    logic               op_is_calc, op_is_div, op_signed;
    logic               a1_neg, a2_neg;
    logic [WIDTH-1:0]   a1_mag, a2_mag;

    // one iteration of the shared datapath
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   step_hi_next, step_lo_next;

    // sign-corrected results presented in FIX
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

    // operand decode: MULT and DIV (op[0]=0) are the signed variants
    always_comb begin
        op_is_calc = ~md_op[2];
        op_is_div  = md_op[1];
        op_signed  = ~md_op[2] & ~md_op[0];
        a1_neg     = op_signed & a1[WIDTH-1];
        a2_neg     = op_signed & a2[WIDTH-1];
        a1_mag     = a1_neg ? -a1 : a1;
        a2_mag     = a2_neg ? -a2 : a2;
    end

    // single iteration: shift-add multiply step and restoring divide step
    always_comb begin
        add_sum   = acc_lo_reg[0] ? ({1'b0, acc_hi_reg} + {1'b0, oper_reg})
                                  : {1'b0, acc_hi_reg};
        div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, oper_reg};
        if (is_div_reg) begin
            // trial MSB clear means the shifted remainder covered the divisor
            if (!div_trial[WIDTH]) begin
                step_hi_next = div_trial[WIDTH-1:0];
                step_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_next = div_shift[WIDTH-1:0];
                step_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_next = add_sum[WIDTH:1];
            step_lo_next = {add_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
    end

    // sign correction of the finished magnitudes
    always_comb begin
        prod_raw = {acc_hi_reg, acc_lo_reg};
        prod_fix = neg_lo_reg ? -prod_raw : prod_raw;
        quot_fix = neg_lo_reg ? -acc_lo_reg : acc_lo_reg;
        rem_fix  = neg_hi_reg ? -acc_hi_reg : acc_hi_reg;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state logic: only MULT*/DIV* enter the iterative path
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && op_is_calc) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_reg == LAST_STEP) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // datapath, HI/LO and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            oper_reg     <= '0;
            raw_a_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            zero_div_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    cnt_reg <= '0;
                    if (start) begin
                        div_zero_reg <= 1'b0;
                        if (op_is_calc) begin
                            acc_hi_reg   <= '0;
                            acc_lo_reg   <= op_is_div ? a1_mag : a2_mag;
                            oper_reg     <= op_is_div ? a2_mag : a1_mag;
                            raw_a_reg    <= a1;
                            is_div_reg   <= op_is_div;
                            neg_lo_reg   <= a1_neg ^ a2_neg;
                            neg_hi_reg   <= a1_neg;
                            zero_div_reg <= op_is_div && (a2 == '0);
                        end else if (md_op == 3'b100) begin
                            hi_reg   <= a1;
                            done_reg <= 1'b1;
                        end else if (md_op == 3'b101) begin
                            lo_reg   <= a1;
                            done_reg <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    acc_hi_reg <= step_hi_next;
                    acc_lo_reg <= step_lo_next;
                    cnt_reg    <= (cnt_reg == LAST_STEP) ? '0 : cnt_reg + CNT_W'(1);
                end
                S_FIX: begin
                    done_reg <= 1'b1;
                    if (!is_div_reg) begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end else if (zero_div_reg) begin
                        hi_reg       <= raw_a_reg;
                        lo_reg       <= '1;
                        div_zero_reg <= 1'b1;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: each task drives one scenario and checks inline.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'b000;
    logic [31:0] a1 = '0;
    logic [31:0] a2 = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .md_op    (md_op),
        .a1       (a1),
        .a2       (a2),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for done; reports cycles from start and busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int cycles, output int busy_cnt, output bit got_done);
        cycles = 0;
        busy_cnt = 0;
        got_done = 0;
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        a1 = x;
        a2 = y;
        while (!got_done && cycles < 60) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) got_done = 1;
        end
        $display("txn op=%0d a1=%h a2=%h -> hi=%h lo=%h dz=%0b cycles=%0d done=%0b",
                 op, x, y, hi, lo, div_zero, cycles, got_done);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, div_zero} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {busy, done, div_zero});
        end
        total++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            bad++;
            $display("FAIL reset_hilo got hi=%h lo=%h want 0/0", hi, lo);
        end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_multu();
        int c, b; bit d;
        run_op(3'b001, 32'd34897, 32'd2389, c, b, d);
        total++;
        if (d !== 1'b1 || c != 34) begin
            bad++;
            $display("FAIL multu_latency got done=%0b cycles=%0d want 1/34", d, c);
        end
        total++;
        if (b != 33) begin
            bad++;
            $display("FAIL multu_busy_cycles got=%0d want=33", b);
        end
        total++;
        if (hi !== 32'd0 || lo !== 32'd83368933) begin
            bad++;
            $display("FAIL multu_result got hi=%h lo=%h want 0/%h", hi, lo, 32'd83368933);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL multu_busy_at_done got=%b want=0", busy);
        end
    endtask

    task automatic test_signed();
        int c, b; bit d;
        run_op(3'b000, 32'hFFFF_FFF9, 32'd3, c, b, d);
        total++;
        if (d !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            bad++;
            $display("FAIL mult_signed got d=%0b hi=%h lo=%h want 1/ffffffff/ffffffeb", d, hi, lo);
        end
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, c, b, d);
        total++;
        if (d !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            bad++;
            $display("FAIL div_signed got d=%0b hi=%h lo=%h want 1/ffffffff/fffffffd", d, hi, lo);
        end
        run_op(3'b010, 32'd100, 32'hFFFF_FFF9, c, b, d);
        total++;
        if (hi !== 32'd2 || lo !== 32'hFFFF_FFF2) begin
            bad++;
            $display("FAIL div_signed_neg_divisor got hi=%h lo=%h want 2/fffffff2", hi, lo);
        end
    endtask

    task automatic test_divu();
        int c, b; bit d;
        run_op(3'b011, 32'd34897, 32'd2389, c, b, d);
        total++;
        if (d !== 1'b1 || c != 34 || hi !== 32'd1451 || lo !== 32'd14 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL divu got d=%0b c=%0d hi=%0d lo=%0d dz=%b want 1/34/1451/14/0",
                     d, c, hi, lo, div_zero);
        end
        run_op(3'b011, 32'd34897, 32'd0, c, b, d);
        total++;
        if (d !== 1'b1 || c != 34) begin
            bad++;
            $display("FAIL divu_zero_latency got d=%0b c=%0d want 1/34", d, c);
        end
        total++;
        if (hi !== 32'd34897 || lo !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
            bad++;
            $display("FAIL divu_zero got hi=%0d lo=%h dz=%b want 34897/ffffffff/1", hi, lo, div_zero);
        end
    endtask

    task automatic test_mthi_mtlo();
        int dones = 0;
        @(negedge clk);
        start = 1'b1; md_op = 3'b100; a1 = 32'h1234; a2 = 32'h0;
        @(negedge clk);
        if (done === 1'b1) dones++;
        total++;
        if (hi !== 32'h1234 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi got hi=%h busy=%b want 1234/0", hi, busy);
        end
        total++;
        if (div_zero !== 1'b0) begin
            bad++;
            $display("FAIL div_zero_clear got=%b want=0", div_zero);
        end
        md_op = 3'b101; a1 = 32'h5678;
        @(negedge clk);
        if (done === 1'b1) dones++;
        start = 1'b0;
        total++;
        if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mtlo got hi=%h lo=%h busy=%b want 1234/5678/0", hi, lo, busy);
        end
        @(negedge clk);
        if (done === 1'b1) dones++;
        total++;
        if (dones != 2) begin
            bad++;
            $display("FAIL mt_done_pulses got=%0d want=2", dones);
        end
        $display("txn mthi/mtlo -> hi=%h lo=%h dones=%0d", hi, lo, dones);
    endtask

    task automatic test_reserved();
        int dones = 0;
        int busies = 0;
        @(negedge clk);
        start = 1'b1; md_op = 3'b110; a1 = 32'hDEAD_BEEF; a2 = 32'h1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busies++;
            @(negedge clk);
        end
        total++;
        if (dones != 0 || busies != 0 || hi !== 32'h1234 || lo !== 32'h5678) begin
            bad++;
            $display("FAIL reserved got dones=%0d busy=%0d hi=%h lo=%h want 0/0/1234/5678",
                     dones, busies, hi, lo);
        end
        $display("txn reserved op -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_corners();
        int c, b; bit d;
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, b, d);
        total++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            bad++;
            $display("FAIL multu_max got hi=%h lo=%h want fffffffe/00000001", hi, lo);
        end
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, c, b, d);
        total++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL div_overflow got hi=%h lo=%h dz=%b want 0/80000000/0", hi, lo, div_zero);
        end
        run_op(3'b010, 32'hFFFF_FFFB, 32'h0, c, b, d);
        total++;
        if (hi !== 32'hFFFF_FFFB || lo !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
            bad++;
            $display("FAIL div_signed_zero got hi=%h lo=%h dz=%b want fffffffb/ffffffff/1",
                     hi, lo, div_zero);
        end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; md_op = 3'b000; a1 = 32'd6; a2 = 32'd7;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 5) begin
                start = 1'b1; md_op = 3'b011; a1 = 32'd100; a2 = 32'd3;
            end
            if (i == 10) begin
                total++;
                if (hi !== 32'hFFFF_FFFB || lo !== 32'hFFFF_FFFF || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL hold_during_busy got hi=%h lo=%h busy=%b want fffffffb/ffffffff/1",
                             hi, lo, busy);
                end
            end
            if (done === 1'b1) begin
                dones++;
                cyc = i;
            end
        end
        total++;
        if (dones != 1 || cyc != 34 || hi !== 32'd0 || lo !== 32'd42) begin
            bad++;
            $display("FAIL busy_ignore got dones=%0d at=%0d hi=%0d lo=%0d want 1/34/0/42",
                     dones, cyc, hi, lo);
        end
        $display("txn mult with ignored divu -> hi=%h lo=%h dones=%0d", hi, lo, dones);
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int c, b; bit d;
        @(negedge clk);
        start = 1'b1; md_op = 3'b010; a1 = 32'd100; a2 = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL reset_mid_no_done got=%0d want=0", dones);
        end
        run_op(3'b011, 32'd100, 32'd7, c, b, d);
        total++;
        if (d !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
            bad++;
            $display("FAIL after_reset_op got d=%0b hi=%0d lo=%0d want 1/2/14", d, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int c, b; bit d;
        int cyc = 0;
        run_op(3'b011, 32'd1000, 32'd9, c, b, d);
        total++;
        if (hi !== 32'd1 || lo !== 32'd111) begin
            bad++;
            $display("FAIL b2b_first got hi=%0d lo=%0d want 1/111", hi, lo);
        end
        // still in the done cycle: issue the next op immediately
        start = 1'b1; md_op = 3'b001; a1 = 32'd25; a2 = 32'd25;
        for (int i = 1; i <= 60 && cyc == 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) cyc = i;
        end
        total++;
        if (cyc != 34 || hi !== 32'd0 || lo !== 32'd625) begin
            bad++;
            $display("FAIL back_to_back got at=%0d hi=%0d lo=%0d want 34/0/625", cyc, hi, lo);
        end
        $display("txn back-to-back multu -> hi=%h lo=%h at=%0d", hi, lo, cyc);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_divu();
        test_mthi_mtlo();
        test_reserved();
        test_corners();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
